// File: rtl/sm_run_ctrl_pkg.sv
// sm_run_ctrl_pkg
//   Shared types and helpers for the schoolMIPS run/halt/step controller.
//   rcState_e : 2-bit controller state (RC_RUN, RC_HALT, RC_STEP)
//   bpMatch   : word-address compare between the fetch address and the
//               breakpoint byte address
package sm_run_ctrl_pkg;

  typedef enum logic [1:0] {
    RC_RUN  = 2'd0,
    RC_HALT = 2'd1,
    RC_STEP = 2'd2
  } rcState_e;

  // Callers pass the breakpoint with its byte-offset bits already dropped,
  // so both operands are 30-bit word addresses.
  function automatic logic bpMatch(input logic [29:0] bpWord,
                                   input logic [29:0] imWord);
    return bpWord == imWord;
  endfunction

endpackage

// File: rtl/sm_run_ctrl_cnt.sv
// sm_run_ctrl_cnt
//   Free-running enable counter, wraps modulo 2^CNT_W.
//   clk   in  clock
//   rst_n in  asynchronous active-low reset, clears the count
//   en    in  count enable, one increment per rising edge while high
//   cnt   out current count
module sm_run_ctrl_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  cnt <= '0;
    else if (en) cnt <= cnt + ONE;
  end

endmodule

// File: rtl/sm_run_ctrl.sv
// sm_run_ctrl
//   Run/halt/single-step controller for the pipelined schoolMIPS core.
//   Produces the global pipeline enable, checks one hardware breakpoint
//   against the fetch address and counts enabled cycles.
//   clk      in  clock
//   rst_n    in  asynchronous active-low reset
//   run_req  in  pulse: resume free running
//   halt_req in  pulse: stop
//   step_req in  pulse: advance exactly one enabled cycle
//   bp_en    in  breakpoint enable (level)
//   bp_addr  in  breakpoint byte address, bits [1:0] ignored
//   imAddr   in  instruction memory word address (pc >> 2)
//   cpu_en   out global pipeline enable (combinational)
//   halted   out controller is in HALT
//   bp_stop  out sticky: last stop came from the breakpoint
//   en_cnt   out number of cycles with cpu_en high
module sm_run_ctrl
  import sm_run_ctrl_pkg::*;
#(
  parameter bit RUN_ON_RESET = 1'b1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      imAddr,
  output logic             cpu_en,
  output logic             halted,
  output logic             bp_stop,
  output logic [CNT_W-1:0] en_cnt
);

  localparam rcState_e RESET_STATE = RUN_ON_RESET ? RC_RUN : RC_HALT;

  rcState_e state;
  logic     skipBp;
  logic     bpHit;

  // Byte-offset bits of the breakpoint and the top of the word address
  // take no part in the compare.
  logic unusedAddrBits;
  assign unusedAddrBits = ^{bp_addr[1:0], imAddr[31:30]};

  // skipBp masks the breakpoint for the first RUN cycle after a resume so
  // the instruction we stopped on gets fetched instead of re-trapping.
  assign bpHit  = bp_en && bpMatch(bp_addr[31:2], imAddr[29:0]) && !skipBp;

  // Drops in the same cycle as the match: the matching instruction stays
  // in F and never reaches D.
  assign cpu_en = ((state == RC_RUN) && !bpHit) || (state == RC_STEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RESET_STATE;
      halted  <= !RUN_ON_RESET;
      skipBp  <= 1'b0;
      bp_stop <= 1'b0;
    end else begin
      case (state)
        RC_RUN: begin
          skipBp <= 1'b0;
          // An explicit halt outranks the breakpoint and does not mark it.
          if (halt_req) begin
            state  <= RC_HALT;
            halted <= 1'b1;
          end else if (bpHit) begin
            state   <= RC_HALT;
            halted  <= 1'b1;
            bp_stop <= 1'b1;
          end
        end
        RC_HALT: begin
          // halt_req has nothing to do here; step outranks run.
          if (step_req) begin
            state   <= RC_STEP;
            halted  <= 1'b0;
            bp_stop <= 1'b0;
          end else if (run_req) begin
            state   <= RC_RUN;
            halted  <= 1'b0;
            skipBp  <= 1'b1;
            bp_stop <= 1'b0;
          end
        end
        RC_STEP: begin
          // The step always completes; halt_req cannot cut it short.
          if (run_req) begin
            state  <= RC_RUN;
            halted <= 1'b0;
            skipBp <= 1'b1;
          end else begin
            state  <= RC_HALT;
            halted <= 1'b1;
          end
        end
        default: begin
          state  <= RC_HALT;
          halted <= 1'b1;
          skipBp <= 1'b0;
        end
      endcase
    end
  end

  sm_run_ctrl_cnt #(
    .CNT_W (CNT_W)
  ) uCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cpu_en),
    .cnt   (en_cnt)
  );

endmodule

// File: tb/tb_sm_run_ctrl.sv
module tb_sm_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_req, halt_req, step_req, bp_en;
  logic [31:0] bp_addr, imAddr;

  // A: defaults (run on reset, 32-bit counter)
  logic        cpuEnA, haltedA, bpStopA;
  logic [31:0] enCntA;
  // B: starts halted
  logic        cpuEnB, haltedB, bpStopB;
  logic [31:0] enCntB;
  // C: 4-bit counter for the wrap check
  logic        cpuEnC, haltedC, bpStopC;
  logic [3:0]  enCntC;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sm_run_ctrl uDutA (
    .clk(clk), .rst_n(rst_n), .run_req(run_req), .halt_req(halt_req),
    .step_req(step_req), .bp_en(bp_en), .bp_addr(bp_addr), .imAddr(imAddr),
    .cpu_en(cpuEnA), .halted(haltedA), .bp_stop(bpStopA), .en_cnt(enCntA)
  );

  sm_run_ctrl #(.RUN_ON_RESET(1'b0)) uDutB (
    .clk(clk), .rst_n(rst_n), .run_req(run_req), .halt_req(halt_req),
    .step_req(step_req), .bp_en(bp_en), .bp_addr(bp_addr), .imAddr(imAddr),
    .cpu_en(cpuEnB), .halted(haltedB), .bp_stop(bpStopB), .en_cnt(enCntB)
  );

  sm_run_ctrl #(.CNT_W(4)) uDutC (
    .clk(clk), .rst_n(rst_n), .run_req(run_req), .halt_req(halt_req),
    .step_req(step_req), .bp_en(bp_en), .bp_addr(bp_addr), .imAddr(imAddr),
    .cpu_en(cpuEnC), .halted(haltedC), .bp_stop(bpStopC), .en_cnt(enCntC)
  );

  typedef struct {
    logic        haltReq, stepReq, runReq, bpEn;
    logic [31:0] bpAddr, imAddr;
    logic        expEn, expHalted, expBpStop;
  } vec_t;

  vec_t vec [27];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clrReq();
    run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
  endtask

  initial begin
    int          enBase, pulses, expCnt;
    logic        stopped;

    // one vector = one cycle; expected outputs are those seen in that cycle
    //            halt  step  run   bpEn  bpAddr        imAddr  en  hlt bps
    vec[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'd0,  1'b1, 1'b0, 1'b0};
    vec[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'd0,  1'b1, 1'b0, 1'b0};
    vec[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'd0,  1'b0, 1'b1, 1'b0};
    vec[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'd0,  1'b0, 1'b1, 1'b0};
    vec[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'd0,  1'b0, 1'b1, 1'b0};
    vec[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'd0,  1'b1, 1'b0, 1'b0};
    vec[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'd0,  1'b0, 1'b1, 1'b0};
    vec[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        32'd0,  1'b0, 1'b1, 1'b0};
    vec[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'd0,  1'b1, 1'b0, 1'b0};
    vec[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'd0,  1'b0, 1'b1, 1'b0};
    vec[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'd0,  1'b0, 1'b1, 1'b0};
    vec[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'd0,  1'b1, 1'b0, 1'b0};
    vec[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        32'd0,  1'b1, 1'b0, 1'b0};
    vec[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'd0,  1'b0, 1'b1, 1'b0};
    vec[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'd0,  1'b0, 1'b1, 1'b0};
    vec[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'd0,  1'b1, 1'b0, 1'b0};
    vec[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'd0,  1'b1, 1'b0, 1'b0};
    vec[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h13,       32'd4,  1'b0, 1'b0, 1'b0};
    vec[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h13,       32'd4,  1'b0, 1'b1, 1'b1};
    vec[19] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h10,       32'd4,  1'b0, 1'b1, 1'b1};
    vec[20] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h10,       32'd4,  1'b1, 1'b0, 1'b0};
    vec[21] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h10,       32'd5,  1'b1, 1'b0, 1'b0};
    vec[22] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h10,       32'd4,  1'b0, 1'b0, 1'b0};
    vec[23] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h10,       32'd4,  1'b0, 1'b1, 1'b1};
    vec[24] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h10,       32'd4,  1'b0, 1'b1, 1'b1};
    vec[25] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h10,       32'd4,  1'b1, 1'b0, 1'b0};
    vec[26] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h10,       32'd4,  1'b0, 1'b1, 1'b0};

    // ---- reset ----
    rst_n = 1'b0; clrReq(); bp_en = 1'b0; bp_addr = '0; imAddr = '0;
    tick(); tick();
    check("rstA_cpu_en", {31'b0, cpuEnA}, 32'd1);
    check("rstA_halted", {31'b0, haltedA}, 32'd0);
    check("rstA_bp_stop", {31'b0, bpStopA}, 32'd0);
    check("rstA_en_cnt", enCntA, 32'd0);
    check("rstB_cpu_en", {31'b0, cpuEnB}, 32'd0);
    check("rstB_halted", {31'b0, haltedB}, 32'd1);
    rst_n = 1'b1;

    // ---- free run: 10 cycles, then on to 17 for the 4-bit wrap ----
    for (int i = 0; i < 10; i++) begin
      check("run_cpu_en", {31'b0, cpuEnA}, 32'd1);
      check("run_halted", {31'b0, haltedA}, 32'd0);
      tick();
    end
    check("run_en_cnt10", enCntA, 32'd10);
    check("run_cnt4_10", {28'b0, enCntC}, 32'd10);
    repeat (7) tick();
    check("run_en_cnt17", enCntA, 32'd17);
    check("cnt4_wrap", {28'b0, enCntC}, 32'd1);
    check("haltB_en_cnt", enCntB, 32'd0);

    // ---- vector table ----
    expCnt = 17;
    for (int i = 0; i < 27; i++) begin
      halt_req = vec[i].haltReq; step_req = vec[i].stepReq;
      run_req  = vec[i].runReq;  bp_en    = vec[i].bpEn;
      bp_addr  = vec[i].bpAddr;  imAddr   = vec[i].imAddr;
      #1;
      check($sformatf("vec%0d_cpu_en", i), {31'b0, cpuEnA}, {31'b0, vec[i].expEn});
      check($sformatf("vec%0d_halted", i), {31'b0, haltedA}, {31'b0, vec[i].expHalted});
      check($sformatf("vec%0d_bp_stop", i), {31'b0, bpStopA}, {31'b0, vec[i].expBpStop});
      if (vec[i].expEn) expCnt++;
      tick();
    end
    clrReq(); bp_en = 1'b0; imAddr = '0;
    check("vec_en_cnt", enCntA, expCnt);

    // ---- resume, halt after a few cycles, then three spaced steps ----
    run_req = 1'b1; tick(); clrReq();
    repeat (4) tick();
    halt_req = 1'b1; #1;
    check("halt_cycle_cpu_en", {31'b0, cpuEnA}, 32'd1);
    tick(); clrReq(); #1;
    check("halt_next_cpu_en", {31'b0, cpuEnA}, 32'd0);
    check("halt_next_halted", {31'b0, haltedA}, 32'd1);
    enBase = enCntA; pulses = 0;
    for (int k = 0; k < 3; k++) begin
      step_req = 1'b1;
      for (int j = 0; j < 4; j++) begin
        #1;
        if (cpuEnA) pulses++;
        tick();
        step_req = 1'b0;
      end
    end
    check("step_pulses", pulses, 32'd3);
    check("step_en_cnt", enCntA - enBase, 32'd3);
    check("step_end_halted", {31'b0, haltedA}, 32'd1);

    // ---- breakpoint at byte 0x10 with a fetch address that advances ----
    bp_en = 1'b1; bp_addr = 32'h10; imAddr = 32'd0;
    run_req = 1'b1; tick(); clrReq();
    stopped = 1'b0;
    for (int i = 0; i < 20 && !stopped; i++) begin
      #1;
      if (!cpuEnA) stopped = 1'b1;
      else begin
        tick();
        imAddr = imAddr + 32'd1;
      end
    end
    check("bp_stopped", {31'b0, stopped}, 32'd1);
    check("bp_stop_addr", imAddr, 32'd4);
    check("bp_hit_not_yet_halted", {31'b0, haltedA}, 32'd0);
    tick();
    check("bp_halted", {31'b0, haltedA}, 32'd1);
    check("bp_sticky", {31'b0, bpStopA}, 32'd1);
    check("bp_halt_cpu_en", {31'b0, cpuEnA}, 32'd0);
    run_req = 1'b1; tick(); clrReq(); #1;
    check("bp_resume_cpu_en", {31'b0, cpuEnA}, 32'd1);
    check("bp_resume_clear", {31'b0, bpStopA}, 32'd0);
    tick(); imAddr = imAddr + 32'd1; #1;
    check("bp_past_cpu_en", {31'b0, cpuEnA}, 32'd1);
    check("bp_past_halted", {31'b0, haltedA}, 32'd0);

    // ---- async reset in the middle of a step (RUN_ON_RESET=0 instance) ----
    bp_en = 1'b0; imAddr = '0;
    halt_req = 1'b1; tick(); clrReq();
    tick(); tick();
    step_req = 1'b1; tick(); clrReq();
    check("B_in_step_cpu_en", {31'b0, cpuEnB}, 32'd1);
    check("B_cnt_nonzero", {31'b0, (enCntB != 32'd0)}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("B_async_cpu_en", {31'b0, cpuEnB}, 32'd0);
    check("B_async_halted", {31'b0, haltedB}, 32'd1);
    check("B_async_en_cnt", enCntB, 32'd0);
    check("A_async_cpu_en", {31'b0, cpuEnA}, 32'd1);
    check("A_async_halted", {31'b0, haltedA}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
